rr_arbiter_8: RTL
=================

Name: rr_arbiter_8

Overview:
- Eight-way round-robin arbiter with grant hold, release handshake and hold timeout.
- Produces a registered 3-bit grant index plus a valid flag.
- Sits directly upstream of the 3-to-8 one-hot decoder. grant_idx drives the decoder select; grant_valid gates the decoded one-hot.
- Guarantees at most one grant at a time, with at least one idle cycle between consecutive grants.

Parameters:
- TIMEOUT, default 16: maximum cycles a grant is held without done before forced release. 0 disables the timeout.
- PTR_RESET, default 0: priority pointer value after reset. Legal range 0..7.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  8  request vector; bit i is requester i, level-sensitive.
- done  in  1  current grantee finished; sampled only in GRANT.
- grant_idx  out  3  index of the granted requester; feeds the decoder select.
- grant_valid  out  1  grant_idx is a live grant.
- timeout_err  out  1  one-cycle pulse when a grant is force-released by timeout.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset asserted: state=IDLE, ptr=PTR_RESET, hold_cnt=0, grant_idx=0, grant_valid=0, timeout_err=0.
  - Takes effect immediately, without a clock edge, including mid-grant.
  - First edge after deassert behaves as IDLE.
- FSM states: IDLE, GRANT, RELEASE. All outputs are registered.
- IDLE, no request (req==0): stay in IDLE; outputs unchanged except grant_valid=0.
- IDLE, any request (req!=0): select the first set bit searching ptr, ptr+1, ... 7, 0, ... ptr-1 (mod-8 wrap).
  - On that edge: grant_idx<=winner, grant_valid<=1, hold_cnt<=0, go to GRANT.
  - Latency: request sampled at edge N; grant visible after edge N.
- GRANT: grant_idx is held stable and hold_cnt increments each cycle. Exit conditions, in priority order:
  - (a) done==1: normal release.
  - (b) req[grant_idx]==0: requester withdrew; normal release, no error.
  - (c) TIMEOUT!=0 and hold_cnt==TIMEOUT-1: forced release; timeout_err<=1 for exactly one cycle.
- On any GRANT exit:
  - grant_valid<=0.
  - ptr<=grant_idx+1 mod 8 (7 wraps to 0).
  - Go to RELEASE.
  - done and timeout on the same cycle: done wins, timeout_err stays 0.
  - grant_valid is therefore high for exactly TIMEOUT cycles on timeout.
- RELEASE: one dead cycle with grant_valid=0, then IDLE unconditionally. Minimum gap between grants is 2 cycles (RELEASE plus IDLE arbitration).
- When grant_valid=0, grant_idx retains its last value. Downstream must qualify with grant_valid.
- hold_cnt: width $clog2(TIMEOUT+1), minimum 1 bit; saturates when TIMEOUT=0.
- req changes on non-granted bits during GRANT are ignored. New requests are considered only in IDLE.
- done asserted outside GRANT is ignored.

Test Plan:
1. rst_n=0 for 3 cycles with req=8'hFF → grant_valid=0, grant_idx=0, timeout_err=0 throughout; first grant after deassert is index 0.
2. req=8'b0010_0000 at edge N, done pulsed at edge N+3 → grant_idx=5 and grant_valid=1 from edge N to N+3 (3 cycles); grant_valid=0 for edges N+4 and N+5; internal ptr=6.
3. req=8'hFF held, done pulsed once per grant → grant sequence 0,1,2,3,4,5,6,7,0 (wrap checked); never two grant_valid cycles without a 2-cycle gap.
4. After a grant to 6, req=8'b0100_0001 → next grant is 0, not 6 (search from 7 wraps to 0).
5. TIMEOUT=4, req[2] held, done=0 → grant_valid high exactly 4 cycles; timeout_err high 1 cycle coincident with the fall; the next grant is 2 again after the gap (only requester). Repeat with done asserted on the 4th cycle → timeout_err=0.
6. rst_n pulsed low mid-GRANT between clock edges → grant_valid drops asynchronously; after release with PTR_RESET=3 and req=8'hFF, first grant is 3.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// rr_arbiter_8
//
// Eight-way round-robin arbiter with grant hold, release handshake and an
// optional hold timeout. Produces a registered grant index plus valid flag
// that drive the select and enable of a downstream 3-to-8 one-hot decoder.
// At most one grant is live at a time, and consecutive grants are separated
// by at least two idle cycles (RELEASE dead cycle plus IDLE arbitration).
//
// State table:
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | no grant; arbitrate over req starting at ptr each cycle
//   ST_GRANT   | grant_idx owns the resource; wait for done/withdraw/timeout
//   ST_RELEASE | one dead cycle after a grant before arbitration resumes
//
// Parameters:
//   TIMEOUT    max cycles a grant is held without done (0 disables timeout)
//   PTR_RESET  priority pointer value after reset (0..7)
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req[7:0]     in   level-sensitive request vector, bit i = requester i
//   done         in   current grantee finished (only looked at in ST_GRANT)
//   grant_idx    out  index of the granted requester (decoder select)
//   grant_valid  out  grant_idx is a live grant
//   timeout_err  out  one-cycle pulse on a timeout-forced release
// ---------------------------------------------------------------------------
module rr_arbiter_8 #(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned PTR_RESET = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout_err
);

    // hold_cnt must be able to reach TIMEOUT-1; keep at least one bit so the
    // counter still exists (and simply saturates) when the timeout is off.
    localparam int unsigned HW     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TC_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    localparam logic [HW-1:0] HOLD_TC  = HW'(TC_INT);
    localparam logic [HW-1:0] HOLD_MAX = {HW{1'b1}};
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    localparam logic [2:0]    PTR_INIT = 3'(PTR_RESET);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t        state_q,       state_d;
    logic [2:0]    ptr_q,         ptr_d;
    logic [HW-1:0] hold_cnt_q,    hold_cnt_d;
    logic [2:0]    grant_idx_q,   grant_idx_d;
    logic          grant_valid_q, grant_valid_d;
    logic          timeout_err_q, timeout_err_d;

    logic          win_found;
    logic [2:0]    win_idx;
    logic [2:0]    cand;
    logic          tmo_hit;

    // Rotating priority search: first set request at ptr, ptr+1, ... with
    // the 3-bit add providing the mod-8 wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign tmo_hit = (TIMEOUT != 0) && (hold_cnt_q == HOLD_TC);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_valid_d = 1'b0;
                if (win_found) begin
                    grant_idx_d   = win_idx;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                    state_d       = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // Exit priority: done, then withdrawal, then timeout. Only a
                // release that neither done nor withdrawal explains is flagged.
                if (done || !req[grant_idx_q] || tmo_hit) begin
                    grant_valid_d = 1'b0;
                    ptr_d         = grant_idx_q + 3'd1;
                    state_d       = ST_RELEASE;
                    timeout_err_d = !done && req[grant_idx_q];
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end

            ST_RELEASE: begin
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end

            default: begin
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= PTR_INIT;
            hold_cnt_q    <= '0;
            grant_idx_q   <= 3'd0;
            grant_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout_err = timeout_err_q;

endmodule
